// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: round-robin multi-master APB interconnect with address decode, error completion and timeout
module apb_intercon_rr #(
  parameter int BUS_WIDTH    = 16,
  parameter int MASTER_PORTS = 2,
  parameter int SLAVE_PORTS  = 4,
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE  = {16'hB0, 16'hA0, 16'h90, 16'h80},
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_LIMIT = {16'hB1, 16'hAF, 16'h9F, 16'h8F},
  parameter int TIMEOUT      = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]        S_PWRITE,
  input  logic [MASTER_PORTS-1:0]        S_PSELx,
  input  logic [MASTER_PORTS-1:0]        S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]        S_PREADY,
  output logic [MASTER_PORTS-1:0]        S_PSLVERR,
  output logic [BUS_WIDTH-1:0]           M_PADDR,
  output logic                           M_PWRITE,
  output logic [SLAVE_PORTS-1:0]         M_PSELx,
  output logic                           M_PENABLE,
  output logic [BUS_WIDTH-1:0]           M_PWDATA,
  input  logic [BUS_WIDTH-1:0]           M_PRDATA,
  input  logic                           M_PREADY,
  input  logic                           M_PSLVERR
);
  localparam int GW = MASTER_PORTS > 1 ? $clog2(MASTER_PORTS) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 r_state, w_next;
  logic [GW-1:0]          r_gnt, r_rr, w_gnt;
  logic [CW-1:0]          r_cnt;
  logic                   r_unmapped;
  logic [BUS_WIDTH-1:0]   w_addr;
  logic [SLAVE_PORTS-1:0] w_sel;
  logic                   w_tmo, w_ok, w_done;
  logic                   w_unused;

  assign w_unused = ^S_PENABLE;

  // Walk downward so the last hit is the first requester at or above the pointer.
  always_comb begin
    logic [GW-1:0] idx;
    idx   = r_rr;
    w_gnt = r_rr;
    for (int i = MASTER_PORTS - 1; i >= 0; i--) begin
      idx = GW'((int'(r_rr) + i) % MASTER_PORTS);
      if (S_PSELx[idx]) w_gnt = idx;
    end
  end

  assign w_addr = S_PADDR[w_gnt*BUS_WIDTH +: BUS_WIDTH];

  always_comb begin
    w_sel = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--)
      if (w_addr >= SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH] && w_addr <= SLAVE_LIMIT[i*BUS_WIDTH +: BUS_WIDTH])
        w_sel = SLAVE_PORTS'(1) << i;
  end

  assign w_tmo  = TIMEOUT > 0 && r_cnt == CW'(TIMEOUT - 1);
  assign w_ok   = M_PREADY && !r_unmapped;
  assign w_done = r_state == ACCESS && (M_PREADY || r_unmapped || w_tmo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |S_PSELx ? SETUP : IDLE;
      SETUP:   w_next = ACCESS;
      ACCESS:  w_next = w_done ? IDLE : ACCESS;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr       <= '0;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_unmapped <= 1'b0;
      M_PADDR    <= '0;
      M_PWRITE   <= 1'b0;
      M_PWDATA   <= '0;
      M_PSELx    <= '0;
      M_PENABLE  <= 1'b0;
    end else if (r_state == IDLE && |S_PSELx) begin
      r_gnt      <= w_gnt;
      r_rr       <= w_gnt == GW'(MASTER_PORTS - 1) ? '0 : w_gnt + 1'b1;
      M_PADDR    <= w_addr;
      M_PWRITE   <= S_PWRITE[w_gnt];
      M_PWDATA   <= S_PWDATA[w_gnt*BUS_WIDTH +: BUS_WIDTH];
      M_PSELx    <= w_sel;
      r_unmapped <= ~|w_sel;
    end else if (r_state == SETUP) begin
      M_PENABLE  <= 1'b1;
    end else if (w_done) begin
      M_PSELx    <= '0;
      M_PENABLE  <= 1'b0;
      r_cnt      <= '0;
    end else if (r_state == ACCESS && !M_PREADY) begin
      r_cnt      <= r_cnt + 1'b1;
    end
  end

  // Unmapped and timed-out transfers return zero data with an error.
  always_comb begin
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    if (w_done) begin
      S_PREADY[r_gnt]                         = 1'b1;
      S_PSLVERR[r_gnt]                        = w_ok ? M_PSLVERR : 1'b1;
      S_PRDATA[r_gnt*BUS_WIDTH +: BUS_WIDTH]  = w_ok ? M_PRDATA : '0;
    end
  end
endmodule
